// File: rtl/regfile_pkg.sv
// Purpose : shared types and default sizes for the scoreboarded register file.
// Latency : n/a (declarations only).
// Backpressure : n/a.
// Contents: state_t (ST_INIT, ST_RUN) and the default DATA_W/ADDR_W/NRD values.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Purpose : per-entry pending-writer (busy) bits plus sticky writeback error.
// Latency : busy/err update at the rising edge after issue/writeback.
// Backpressure : none; issue and writeback are accepted every RUN cycle.
// Ports: clk, rst (sync, active-high), run (block in RUN), iss_en/iss_addr,
//        wr_en/wr_addr, busy (one bit per entry), err (sticky).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     err
);

  logic [(1<<ADDR_W)-1:0] busy_q;
  logic [(1<<ADDR_W)-1:0] busy_d;
  logic                   iss_ok;
  logic                   wr_ok;

  // Entry 0 is hardwired zero, so it can never gain or retire a producer.
  assign iss_ok = run && iss_en && (iss_addr != '0);
  assign wr_ok  = run && wr_en  && (wr_addr  != '0);

  // Clear first, then set: a same-cycle issue to the written entry keeps it
  // busy, since the newly issued producer is still outstanding.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      err    <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (wr_ok && !busy_q[wr_addr]) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Purpose : register file with NRD synchronous read ports, one write port and
//           a busy scoreboard; clears itself one entry per cycle after reset.
// Latency : read data 1 cycle after address; rd_busy combinational.
// Backpressure : none; ready stays low for DEPTH cycles after reset.
// Ports: clk, rst (sync, active-high), rd_addr/rd_data/rd_busy (packed per port),
//        wr_en/wr_addr/wr_data (writeback), iss_en/iss_addr (issue), ready, err.
// Option: define REGFILE_BYPASS_EN for write-first reads of the entry being
//         written; otherwise reads return the pre-write contents.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*ADDR_W-1:0]  rd_addr,
  output logic [NRD*DATA_W-1:0]  rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic                   ready,
  output logic                   err
);

  localparam int DEPTH = 1 << ADDR_W;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   clr_cnt;
  logic [ADDR_W-1:0]   clr_cnt_nxt;
  logic                run;
  logic                wr_ok;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    busy;
  logic [NRD*DATA_W-1:0] rd_nxt;

  // ---------------- init / run FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_INIT: begin
        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
        // The counter wraps back to 0 as the last entry is cleared.
        if (&clr_cnt) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt   = ST_INIT;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  assign run   = (state == ST_RUN);
  assign ready = run;
  assign wr_ok = run && wr_en && (wr_addr != '0);

  // ---------------- storage ----------------
  // No reset on the array itself: the INIT sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[clr_cnt] <= '0;
      end else if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  // ---------------- scoreboard ----------------
  regfile_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy),
    .err      (err)
  );

`ifdef REGFILE_BYPASS_EN
  logic iss_ok;
  assign iss_ok = iss_en && (iss_addr != '0);
`endif

  // ---------------- read ports ----------------
  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [ADDR_W-1:0] a;
    logic              fwd;

    assign a = rd_addr[p*ADDR_W +: ADDR_W];

`ifdef REGFILE_BYPASS_EN
    assign fwd = wr_ok && (a == wr_addr);
`else
    assign fwd = 1'b0;
`endif

    // Entry 0 is forced to zero so it reads clean even before the first sweep.
    assign rd_nxt[p*DATA_W +: DATA_W] =
      (!run || (a == '0)) ? '0 : (fwd ? wr_data : mem[a]);

    // A forwarded read sees the value being retired, so it is only busy
    // again if a new producer is issued to that entry in the same cycle.
`ifdef REGFILE_BYPASS_EN
    assign rd_busy[p] = run && (a != '0) &&
                        (fwd ? (iss_ok && (iss_addr == a)) : busy[a]);
`else
    assign rd_busy[p] = run && (a != '0) && !fwd && busy[a];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_nxt;
    end
  end

endmodule
